vga_timing_gen: RTL and testbench

Upstream timing stage of the VGA character path. Generates 640x480@60 Hz horizontal/vertical counters, active-low sync pulses and a display-enable window. Issues pixel coordinate requests one cycle ahead of the active pixel to the pixel-generation stage (`vga_display`). Merges the returned 24-bit pixel into the blanked RGB output.

---
 rtl/vga_timing_pkg.sv | 41 ++++
 rtl/vga_color_bar.sv | 25 ++
 rtl/vga_timing_gen.sv | 101 ++++++++++
 tb/tb_vga_timing_gen.sv | 375 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_timing_pkg.sv
// Shared 640x480@60 timing constants and colour values for the VGA timing path.
// Pure declarations; no logic or latency. Colour bars optional via VGA_TEST_PATTERN_EN.
// No flow control involved.
package vga_timing_pkg;

  localparam int DEF_H_SYNC  = 96;
  localparam int DEF_H_BACK  = 48;
  localparam int DEF_H_DISP  = 640;
  localparam int DEF_H_FRONT = 16;
  localparam int DEF_V_SYNC  = 2;
  localparam int DEF_V_BACK  = 33;
  localparam int DEF_V_DISP  = 480;
  localparam int DEF_V_FRONT = 10;

  localparam int DEF_H_TOTAL = DEF_H_SYNC + DEF_H_BACK + DEF_H_DISP + DEF_H_FRONT;
  localparam int DEF_V_TOTAL = DEF_V_SYNC + DEF_V_BACK + DEF_V_DISP + DEF_V_FRONT;

  localparam logic [23:0] WHITE   = 24'hFFFFFF;
  localparam logic [23:0] BLACK   = 24'h000000;
  localparam logic [23:0] RED     = 24'hFF0000;
  localparam logic [23:0] GREEN   = 24'h00FF00;
  localparam logic [23:0] BLUE    = 24'h0000FF;
  localparam logic [23:0] YELLOW  = 24'hFFFF00;
  localparam logic [23:0] CYAN    = 24'h00FFFF;
  localparam logic [23:0] MAGENTA = 24'hFF00FF;

  // Standard SMPTE-like bar order, left to right.
  function automatic logic [23:0] bar_color(input logic [2:0] idx);
    case (idx)
      3'd0:    return WHITE;
      3'd1:    return YELLOW;
      3'd2:    return CYAN;
      3'd3:    return GREEN;
      3'd4:    return MAGENTA;
      3'd5:    return RED;
      3'd6:    return BLUE;
      default: return BLACK;
    endcase
  endfunction

endpackage

// File: rtl/vga_color_bar.sv
// Eight-bar colour pattern indexed by active column; used only with VGA_TEST_PATTERN_EN.
// Latency: purely combinational.
// Backpressure: none.
module vga_color_bar
  import vga_timing_pkg::*;
#(
  parameter int BAR_W = DEF_H_DISP / 8
) (
  input  logic [9:0]  col,
  output logic [23:0] rgb
);

  localparam logic [9:0] BAR_W_L = 10'(BAR_W);

  logic [9:0] idx;

  always_comb begin
    idx = col / BAR_W_L;
    rgb = BLACK;
    if (idx < 10'd8) begin
      rgb = bar_color(idx[2:0]);
    end
  end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA h/v counters, active-low syncs, display window and pixel request; VGA_TEST_PATTERN_EN adds colour bars.
// Latency: coordinates requested one clock before the matching vga_de cycle; outputs decode counters combinationally.
// Backpressure: none; the pixel stage must return pixel_data the cycle after data_req.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int H_SYNC  = DEF_H_SYNC,
  parameter int H_BACK  = DEF_H_BACK,
  parameter int H_DISP  = DEF_H_DISP,
  parameter int H_FRONT = DEF_H_FRONT,
  parameter int V_SYNC  = DEF_V_SYNC,
  parameter int V_BACK  = DEF_V_BACK,
  parameter int V_DISP  = DEF_V_DISP,
  parameter int V_FRONT = DEF_V_FRONT
) (
  input  logic        vga_clk,
  input  logic        sys_rst,
  input  logic        pattern_en,
  input  logic [23:0] pixel_data,
  output logic [9:0]  pixel_xpos,
  output logic [9:0]  pixel_ypos,
  output logic        data_req,
  output logic        vga_hs,
  output logic        vga_vs,
  output logic        vga_de,
  output logic [23:0] vga_rgb
);

  localparam int H_TOTAL = H_SYNC + H_BACK + H_DISP + H_FRONT;
  localparam int V_TOTAL = V_SYNC + V_BACK + V_DISP + V_FRONT;

  localparam logic [9:0] H_LAST    = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST    = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_SYNC_L  = 10'(H_SYNC);
  localparam logic [9:0] V_SYNC_L  = 10'(V_SYNC);
  localparam logic [9:0] H_ACT     = 10'(H_SYNC + H_BACK);
  localparam logic [9:0] H_ACT_END = 10'(H_SYNC + H_BACK + H_DISP);
  localparam logic [9:0] H_REQ     = 10'(H_SYNC + H_BACK - 1);
  localparam logic [9:0] H_REQ_END = 10'(H_SYNC + H_BACK + H_DISP - 1);
  localparam logic [9:0] V_ACT     = 10'(V_SYNC + V_BACK);
  localparam logic [9:0] V_ACT_END = 10'(V_SYNC + V_BACK + V_DISP);

  logic [9:0]  h_cnt_q, h_cnt_d;
  logic [9:0]  v_cnt_q, v_cnt_d;
  logic        v_act;
  logic [23:0] src_rgb;

  always_comb begin
    h_cnt_d = h_cnt_q + 10'd1;
    v_cnt_d = v_cnt_q;
    if (h_cnt_q == H_LAST) begin
      h_cnt_d = '0;
      v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + 10'd1;
    end
  end

  always_ff @(posedge vga_clk or posedge sys_rst) begin
    if (sys_rst) begin
      h_cnt_q <= '0;
      v_cnt_q <= '0;
    end else begin
      h_cnt_q <= h_cnt_d;
      v_cnt_q <= v_cnt_d;
    end
  end

  always_comb begin
    vga_hs   = (h_cnt_q >= H_SYNC_L);
    vga_vs   = (v_cnt_q >= V_SYNC_L);
    v_act    = (v_cnt_q >= V_ACT) && (v_cnt_q < V_ACT_END);
    vga_de   = v_act && (h_cnt_q >= H_ACT) && (h_cnt_q < H_ACT_END);
    // Request leads the display window by one clock so pixel_data lines up with vga_de.
    data_req = v_act && (h_cnt_q >= H_REQ) && (h_cnt_q < H_REQ_END);
    pixel_xpos = data_req ? (h_cnt_q - H_REQ) : '0;
    pixel_ypos = data_req ? (v_cnt_q - V_ACT) : '0;
  end

`ifdef VGA_TEST_PATTERN_EN
  logic [9:0]  active_col;
  logic [23:0] bar_rgb;

  assign active_col = h_cnt_q - H_ACT;

  vga_color_bar #(
    .BAR_W(H_DISP / 8)
  ) u_color_bar (
    .col(active_col),
    .rgb(bar_rgb)
  );

  assign src_rgb = pattern_en ? bar_rgb : pixel_data;
`else
  logic unused_pattern_en;

  assign unused_pattern_en = pattern_en;
  assign src_rgb           = pixel_data;
`endif

  assign vga_rgb = vga_de ? src_rgb : 24'h000000;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench: full-size instance for absolute 640x480 timing, shrunken instance for whole-frame checks,
// both compared against a frame-position model derived from elapsed clocks since reset.
module tb_vga_timing_gen;

  localparam int SHS = 4, SHB = 3, SHD = 16, SHF = 2;
  localparam int SVS = 2, SVB = 3, SVD = 6,  SVF = 2;
  localparam int S_FRAME = (SHS + SHB + SHD + SHF) * (SVS + SVB + SVD + SVF);

  logic        clk = 1'b0;
  logic        rst;
  logic        pattern_en;
  logic [23:0] pixel_data;

  logic [9:0]  d_xpos, d_ypos, s_xpos, s_ypos;
  logic        d_req, d_hs, d_vs, d_de, s_req, s_hs, s_vs, s_de;
  logic [23:0] d_rgb, s_rgb;

  int     checks = 0;
  int     errors = 0;
  longint cyc;

  typedef struct packed {
    logic        hs;
    logic        vs;
    logic        de;
    logic        req;
    logic [9:0]  x;
    logic [9:0]  y;
    logic [23:0] rgb;
  } obs_t;

  always #20 clk = ~clk;

  // Elapsed clock edges since the last reset release.
  always @(posedge clk or posedge rst) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  vga_timing_gen u_dut (
    .vga_clk(clk), .sys_rst(rst), .pattern_en(pattern_en), .pixel_data(pixel_data),
    .pixel_xpos(d_xpos), .pixel_ypos(d_ypos), .data_req(d_req),
    .vga_hs(d_hs), .vga_vs(d_vs), .vga_de(d_de), .vga_rgb(d_rgb)
  );

  vga_timing_gen #(
    .H_SYNC(SHS), .H_BACK(SHB), .H_DISP(SHD), .H_FRONT(SHF),
    .V_SYNC(SVS), .V_BACK(SVB), .V_DISP(SVD), .V_FRONT(SVF)
  ) u_small (
    .vga_clk(clk), .sys_rst(rst), .pattern_en(pattern_en), .pixel_data(pixel_data),
    .pixel_xpos(s_xpos), .pixel_ypos(s_ypos), .data_req(s_req),
    .vga_hs(s_hs), .vga_vs(s_vs), .vga_de(s_de), .vga_rgb(s_rgb)
  );

  function automatic obs_t model(input longint t, input int hs, input int hb, input int hd, input int hf,
                                 input int vs, input int vb, input int vd, input int vf,
                                 input logic [23:0] pd, input logic pe);
    obs_t e;
    int   ht, vt, h, v, col;
    logic in_v;
    ht = hs + hb + hd + hf;
    vt = vs + vb + vd + vf;
    h  = int'(t % longint'(ht));
    v  = int'((t / longint'(ht)) % longint'(vt));
    in_v  = (v >= vs + vb) && (v < vs + vb + vd);
    e.hs  = (h >= hs);
    e.vs  = (v >= vs);
    e.de  = in_v && (h >= hs + hb) && (h < hs + hb + hd);
    e.req = in_v && (h >= hs + hb - 1) && (h < hs + hb + hd - 1);
    e.x   = e.req ? 10'(h - (hs + hb - 1)) : 10'd0;
    e.y   = e.req ? 10'(v - (vs + vb)) : 10'd0;
    e.rgb = 24'h0;
    if (e.de) begin
      e.rgb = pd;
`ifdef VGA_TEST_PATTERN_EN
      if (pe) begin
        col = h - (hs + hb);
        case (col / (hd / 8))
          0: e.rgb = 24'hFFFFFF;
          1: e.rgb = 24'hFFFF00;
          2: e.rgb = 24'h00FFFF;
          3: e.rgb = 24'h00FF00;
          4: e.rgb = 24'hFF00FF;
          5: e.rgb = 24'hFF0000;
          6: e.rgb = 24'h0000FF;
          default: e.rgb = 24'h000000;
        endcase
      end
`else
      col = 0;
      if (pe) e.rgb = pd;
`endif
    end
    return e;
  endfunction

  function automatic obs_t exp_d();
    return model(cyc, 96, 48, 640, 16, 2, 33, 480, 10, pixel_data, pattern_en);
  endfunction

  function automatic obs_t exp_s();
    return model(cyc, SHS, SHB, SHD, SHF, SVS, SVB, SVD, SVF, pixel_data, pattern_en);
  endfunction

  function automatic obs_t act_d();
    return {d_hs, d_vs, d_de, d_req, d_xpos, d_ypos, d_rgb};
  endfunction

  function automatic obs_t act_s();
    return {s_hs, s_vs, s_de, s_req, s_xpos, s_ypos, s_rgb};
  endfunction

  // Advance one clock, apply new inputs away from the edge, settle.
  task automatic step(input logic [23:0] pd, input logic pe);
    @(posedge clk);
    #1;
    pixel_data = pd;
    pattern_en = pe;
    #1;
  endtask

  task automatic test_reset();
    int first_hs, first_vs, fall1, fall2;
    logic prev_hs;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    repeat (500 + $urandom_range(0, 200)) step(24'($urandom), 1'b0);
    pixel_data = 24'hFFFFFF;
    #5 rst = 1'b1;
    #1;
    checks++;
    if (act_d() !== obs_t'(0)) begin
      errors++;
      $display("FAIL reset_async_full actual=%h required=0", act_d());
    end
    checks++;
    if (act_s() !== obs_t'(0)) begin
      errors++;
      $display("FAIL reset_async_small actual=%h required=0", act_s());
    end
    @(posedge clk);
    #1;
    checks++;
    if (act_d() !== obs_t'(0)) begin
      errors++;
      $display("FAIL reset_held actual=%h required=0", act_d());
    end
    rst = 1'b0;
    first_hs = -1; first_vs = -1; fall1 = -1; fall2 = -1; prev_hs = 1'b0;
    for (int i = 1; i <= 1700; i++) begin
      step(24'($urandom), 1'($urandom));
      if (d_hs && first_hs < 0) first_hs = i;
      if (d_vs && first_vs < 0) first_vs = i;
      if (prev_hs && !d_hs) begin
        if (fall1 < 0) fall1 = i;
        else if (fall2 < 0) fall2 = i;
      end
      prev_hs = d_hs;
      checks++;
      if (act_d() !== exp_d()) begin
        errors++;
        $display("FAIL reset_release_full t=%0d actual=%h required=%h", cyc, act_d(), exp_d());
      end
    end
    checks++;
    if (first_hs != 96) begin
      errors++;
      $display("FAIL hs_rise_clock actual=%0d required=96", first_hs);
    end
    checks++;
    if (first_vs != 1600) begin
      errors++;
      $display("FAIL vs_low_clocks actual=%0d required=1600", first_vs);
    end
    checks++;
    if (fall1 != 800 || fall2 - fall1 != 800) begin
      errors++;
      $display("FAIL line_period actual=%0d,%0d required=800,800", fall1, fall2 - fall1);
    end
  endtask

  task automatic test_vsync();
    int f1, f2, low;
    logic prev_vs;
    f1 = -1; f2 = -1; low = 0; prev_vs = s_vs;
    for (int i = 0; i < 3 * S_FRAME; i++) begin
      step(24'($urandom), 1'($urandom));
      if (prev_vs && !s_vs) begin
        if (f1 < 0) f1 = i;
        else if (f2 < 0) f2 = i;
      end
      if (f1 >= 0 && f2 < 0 && !s_vs) low++;
      prev_vs = s_vs;
      checks++;
      if (act_s() !== exp_s()) begin
        errors++;
        $display("FAIL vsync_small t=%0d actual=%h required=%h", cyc, act_s(), exp_s());
      end
    end
    checks++;
    if (f1 < 0 || f2 < 0 || f2 - f1 != S_FRAME) begin
      errors++;
      $display("FAIL frame_period actual=%0d required=%0d", f2 - f1, S_FRAME);
    end
    checks++;
    if (low != SVS * (SHS + SHB + SHD + SHF)) begin
      errors++;
      $display("FAIL vs_low_per_frame actual=%0d required=%0d", low, SVS * (SHS + SHB + SHD + SHF));
    end
  endtask

  task automatic test_blanking();
    int n;
    n = 0;
    while (cyc < 35 * 800 - 1 && n < 40000) begin
      step(24'hFFFFFF, 1'($urandom));
      n++;
      checks++;
      if (d_rgb !== 24'h0 || d_req !== 1'b0 || d_de !== 1'b0) begin
        errors++;
        $display("FAIL blanking t=%0d actual rgb=%h req=%b de=%b required 0", cyc, d_rgb, d_req, d_de);
      end
    end
    checks++;
    if (cyc != 35 * 800 - 1) begin
      errors++;
      $display("FAIL blanking_reach actual=%0d required=%0d", cyc, 35 * 800 - 1);
    end
  endtask

  task automatic test_request_window();
    logic [23:0] pd;
    for (int i = 0; i < 785; i++) begin
      pd = 24'($urandom);
      step(pd, 1'b0);
      if (cyc == 28000 + 142) begin
        checks++;
        if (d_req !== 1'b0) begin
          errors++;
          $display("FAIL req_before_window actual=%b required=0", d_req);
        end
      end
      if (cyc == 28000 + 143) begin
        checks++;
        if (d_req !== 1'b1 || d_xpos !== 10'd0 || d_ypos !== 10'd0 || d_de !== 1'b0) begin
          errors++;
          $display("FAIL first_request actual req=%b x=%0d y=%0d de=%b required 1,0,0,0",
                   d_req, d_xpos, d_ypos, d_de);
        end
      end
      if (cyc == 28000 + 782) begin
        checks++;
        if (d_req !== 1'b1 || d_xpos !== 10'd639) begin
          errors++;
          $display("FAIL last_request actual req=%b x=%0d required 1,639", d_req, d_xpos);
        end
      end
      if (cyc == 28000 + 783) begin
        checks++;
        if (d_req !== 1'b0 || d_de !== 1'b1 || d_rgb !== pd) begin
          errors++;
          $display("FAIL last_pixel actual req=%b de=%b rgb=%h required 0,1,%h", d_req, d_de, d_rgb, pd);
        end
      end
    end
  endtask

  task automatic test_pixel_path();
    int de_cnt, red_cnt;
    de_cnt = 0; red_cnt = 0;
    for (int i = 0; i < S_FRAME; i++) begin
      step(24'hFF0000, 1'b0);
      if (s_de) de_cnt++;
      if (s_rgb == 24'hFF0000) red_cnt++;
      checks++;
      if (act_s() !== exp_s()) begin
        errors++;
        $display("FAIL pixel_small t=%0d actual=%h required=%h", cyc, act_s(), exp_s());
      end
      checks++;
      if (act_d() !== exp_d()) begin
        errors++;
        $display("FAIL pixel_full t=%0d actual=%h required=%h", cyc, act_d(), exp_d());
      end
    end
    checks++;
    if (de_cnt != SHD * SVD || red_cnt != SHD * SVD) begin
      errors++;
      $display("FAIL de_per_frame actual=%0d/%0d required=%0d", de_cnt, red_cnt, SHD * SVD);
    end
    for (int i = 0; i < 600; i++) begin
      step(24'($urandom), 1'($urandom));
      checks++;
      if (act_s() !== exp_s() || act_d() !== exp_d()) begin
        errors++;
        $display("FAIL random_path t=%0d actual=%h/%h required=%h/%h", cyc, act_s(), act_d(), exp_s(), exp_d());
      end
    end
  endtask

  task automatic test_pattern();
    logic [23:0] pd, req_rgb;
    int          col;
    logic        chk;
    for (int i = 0; i < 900; i++) begin
      pd  = 24'($urandom);
      step(pd, (i < 800));
      col = int'(cyc % 800) - 144;
      chk = 1'b0;
      req_rgb = pd;
      if (d_de && i < 800) begin
`ifdef VGA_TEST_PATTERN_EN
        if (col < 80)        begin chk = 1'b1; req_rgb = 24'hFFFFFF; end
        else if (col < 160)  begin chk = 1'b1; req_rgb = 24'hFFFF00; end
        else if (col >= 560) begin chk = 1'b1; req_rgb = 24'h000000; end
`else
        chk = 1'b1;
`endif
      end else if (d_de) begin
        chk = 1'b1;
      end
      if (chk) begin
        checks++;
        if (d_rgb !== req_rgb) begin
          errors++;
          $display("FAIL pattern col=%0d pe=%b actual=%h required=%h", col, pattern_en, d_rgb, req_rgb);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    repeat ($urandom_range(10, 300)) step(24'($urandom), 1'($urandom));
    rst = 1'b1;
    #3;
    checks++;
    if (act_d() !== obs_t'(0) || act_s() !== obs_t'(0)) begin
      errors++;
      $display("FAIL midframe_reset actual=%h/%h required=0", act_d(), act_s());
    end
    @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 0; i < 2 * S_FRAME; i++) begin
      step(24'($urandom), 1'($urandom));
      checks++;
      if (act_s() !== exp_s() || act_d() !== exp_d()) begin
        errors++;
        $display("FAIL restart t=%0d actual=%h/%h required=%h/%h", cyc, act_s(), act_d(), exp_s(), exp_d());
      end
    end
  endtask

  initial begin
    #(60000 * 40);
    $display("FAIL watchdog expired after %0d clocks", 60000);
    $fatal(1, "watchdog");
  end

  initial begin
    rst        = 1'b1;
    pattern_en = 1'b0;
    pixel_data = 24'h0;
    test_reset();
    test_vsync();
    test_blanking();
    test_request_window();
    test_pixel_path();
    test_pattern();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
